// File: rtl/aes128_decrypt_core.sv
// Iterative AES-128 inverse cipher: one round per clock, forward key expansion to rk10,
// inverse key schedule during the rounds, optional rk10 cache for repeated keys.

package aes_gf_pkg;
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction
endpackage

module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  import aes_gf_pkg::*;
  logic [7:0] inv;
  assign inv = gf_inv(x);
  assign y = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
endmodule

module aes_inv_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  import aes_gf_pkg::*;
  assign y = gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
endmodule

module aes128_decrypt_core #(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] ciphertext_in,
  input  logic [127:0] key_in,
  output logic [127:0] plaintext_out,
  output logic         busy,
  output logic         done
);
  import aes_gf_pkg::*;

  typedef enum logic [1:0] {IDLE, KEXP, ROUND} fsm_t;

  fsm_t         fsm;
  logic [3:0]   round;
  logic [127:0] state_q, key_q, cache_rk, cache_key;
  logic         cache_valid;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Key schedule: the four forward S-boxes serve both directions. Forward expansion
  // substitutes w3 of the current key; the inverse step substitutes w3 of the
  // previous round key, which is w2 ^ w3 of the current one.
  logic [31:0]  kw [4];
  logic [31:0]  sb_in, sb_rot, sb_out, f_word;
  logic [7:0]   rcon_sel;
  logic [127:0] fwd_key, rk_r;

  for (genvar i = 0; i < 4; i++) begin : g_kw
    assign kw[i] = key_q[127-32*i -: 32];
    aes_sbox u_sbox (.x(sb_rot[8*i +: 8]), .y(sb_out[8*i +: 8]));
  end

  assign sb_in    = (fsm == ROUND) ? (kw[2] ^ kw[3]) : kw[3];
  assign sb_rot   = {sb_in[23:0], sb_in[31:24]};
  assign rcon_sel = (fsm == ROUND) ? rcon(round + 4'd1) : rcon(round);
  assign f_word   = sb_out ^ {rcon_sel, 24'h0};

  assign fwd_key = {kw[0] ^ f_word,
                    kw[1] ^ kw[0] ^ f_word,
                    kw[2] ^ kw[1] ^ kw[0] ^ f_word,
                    kw[3] ^ kw[2] ^ kw[1] ^ kw[0] ^ f_word};
  assign rk_r    = {kw[0] ^ f_word, kw[1] ^ kw[0], kw[2] ^ kw[1], kw[3] ^ kw[2]};

  // Round datapath; byte b sits at row b%4, column b/4.
  logic [7:0]   st_b [16];
  logic [7:0]   isr_b [16];
  logic [7:0]   isb_b [16];
  logic [7:0]   ark_b [16];
  logic [7:0]   imc_b [16];
  logic [127:0] round_out;

  for (genvar b = 0; b < 16; b++) begin : g_byte
    localparam int R = b % 4;
    localparam int C = b / 4;
    assign st_b[b]  = state_q[127-8*b -: 8];
    assign isr_b[b] = st_b[R + 4*((C + 4 - R) % 4)];
    aes_inv_sbox u_inv_sbox (.x(isr_b[b]), .y(isb_b[b]));
    assign ark_b[b] = isb_b[b] ^ rk_r[127-8*b -: 8];
    assign round_out[127-8*b -: 8] = (round == 4'd0) ? ark_b[b] : imc_b[b];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign imc_b[4*c+0] = gf_mul(ark_b[4*c], 8'h0e) ^ gf_mul(ark_b[4*c+1], 8'h0b)
                        ^ gf_mul(ark_b[4*c+2], 8'h0d) ^ gf_mul(ark_b[4*c+3], 8'h09);
    assign imc_b[4*c+1] = gf_mul(ark_b[4*c], 8'h09) ^ gf_mul(ark_b[4*c+1], 8'h0e)
                        ^ gf_mul(ark_b[4*c+2], 8'h0b) ^ gf_mul(ark_b[4*c+3], 8'h0d);
    assign imc_b[4*c+2] = gf_mul(ark_b[4*c], 8'h0d) ^ gf_mul(ark_b[4*c+1], 8'h09)
                        ^ gf_mul(ark_b[4*c+2], 8'h0e) ^ gf_mul(ark_b[4*c+3], 8'h0b);
    assign imc_b[4*c+3] = gf_mul(ark_b[4*c], 8'h0b) ^ gf_mul(ark_b[4*c+1], 8'h0d)
                        ^ gf_mul(ark_b[4*c+2], 8'h09) ^ gf_mul(ark_b[4*c+3], 8'h0e);
  end

  // NOTE: the cache registers are reset along with everything else, so a reset
  // mid-operation can never leave a half-written rk10 marked valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm           <= IDLE;
      round         <= '0;
      state_q       <= '0;
      key_q         <= '0;
      cache_rk      <= '0;
      cache_key     <= '0;
      cache_valid   <= 1'b0;
      plaintext_out <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register see pre-edge values,
      // so state_q and key_q advance in lockstep regardless of statement order.
      done <= 1'b0;
      unique case (fsm)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (KEY_CACHE && cache_valid && (key_in == cache_key)) begin
            key_q   <= cache_rk;
            state_q <= ciphertext_in ^ cache_rk;
            round   <= 4'd9;
            fsm     <= ROUND;
          end else begin
            key_q       <= key_in;
            state_q     <= ciphertext_in;
            cache_key   <= key_in;
            cache_valid <= 1'b0;
            round       <= 4'd1;
            fsm         <= KEXP;
          end
        end
        KEXP: begin
          key_q <= fwd_key;
          if (round == 4'd10) begin
            state_q     <= state_q ^ fwd_key;
            cache_rk    <= fwd_key;
            cache_valid <= 1'b1;
            round       <= 4'd9;
            fsm         <= ROUND;
          end else begin
            round <= round + 4'd1;
          end
        end
        ROUND: begin
          key_q   <= rk_r;
          state_q <= round_out;
          if (round == 4'd0) begin
            plaintext_out <= round_out;
            done          <= 1'b1;
            busy          <= 1'b0;
            fsm           <= IDLE;
          end else begin
            round <= round - 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_decrypt_core.sv
// Self-checking bench for aes128_decrypt_core: FIPS-197 vectors, cache, start/reset corner
// cases, and random loopback against a table-driven AES encryption model.

module tb_aes128_decrypt_core;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         start_c, start_n;
  logic [127:0] ciphertext_in, key_in;
  logic [127:0] plaintext_c, plaintext_n;
  logic         busy_c, busy_n, done_c, done_n;

  int total = 0;
  int bad   = 0;

  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  aes128_decrypt_core #(.KEY_CACHE(1'b1)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .ciphertext_in(ciphertext_in),
    .key_in(key_in), .plaintext_out(plaintext_c), .busy(busy_c), .done(done_c));

  aes128_decrypt_core #(.KEY_CACHE(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .start(start_n), .ciphertext_in(ciphertext_in),
    .key_in(key_in), .plaintext_out(plaintext_n), .busy(busy_n), .done(done_n));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: carry-less product reduced by 0x11b, S-box by exhaustive inverse search.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
    return p[7:0];
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv, y, cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int v = 1; v < 256; v++) if (gmul(8'(x), 8'(v)) == 8'h01) inv = 8'(v);
      for (int i = 0; i < 8; i++)
        y[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sbox_t[x] = y;
    end
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int n = 1; n <= 10; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r+4*c] = sbox_t[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (n < 10) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int b = 0; b < 16; b++) s[b] ^= w[4*n + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic done_of(input bit which);
    return which ? done_n : done_c;
  endfunction

  function automatic logic busy_of(input bit which);
    return which ? busy_n : busy_c;
  endfunction

  // Called right after a start edge; returns edges until done is seen (-1 on timeout).
  task automatic wait_done(input bit which, output int lat);
    bit ok;
    ok  = 1'b1;
    lat = -1;
    #1;
    start_c = 1'b0;
    start_n = 1'b0;
    if (busy_of(which) !== 1'b1) ok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done_of(which) === 1'b1) begin
        lat = k;
        if (busy_of(which) !== 1'b0) ok = 1'b0;
        break;
      end
      if (busy_of(which) !== 1'b1) ok = 1'b0;
    end
    check(which ? "busy_window_n" : "busy_window_c", 128'(ok), 128'(1'b1));
  endtask

  task automatic run_op(input bit which, input logic [127:0] ct, input logic [127:0] key,
                        output int lat);
    @(negedge clk);
    ciphertext_in = ct;
    key_in        = key;
    if (which) start_n = 1'b1;
    else start_c = 1'b1;
    @(posedge clk);
    wait_done(which, lat);
  endtask

  initial begin
    logic [127:0] k_c1, ct_c1, pt_c1, k_b, ct_b, pt_b, k_r, pt_r, ct_r, k_l, pt_l, ct_l;
    int lat, ndone;

    k_c1  = 128'h000102030405060708090a0b0c0d0e0f;
    ct_c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pt_c1 = 128'h00112233445566778899aabbccddeeff;
    k_b   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;
    pt_b  = 128'h3243f6a8885a308d313198a2e0370734;

    build_sbox();
    reset_n = 1'b0;
    start_c = 1'b0;
    start_n = 1'b0;
    ciphertext_in = '0;
    key_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pt", plaintext_c, '0);
    check("rst_busy", 128'(busy_c), '0);
    check("rst_done", 128'(done_c), '0);
    check("rst_busy_n", 128'(busy_n), '0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(1'b0, ct_c1, k_c1, lat);
    check("c1_lat", 128'(lat), 128'(20));
    check("c1_pt", plaintext_c, pt_c1);

    run_op(1'b0, ct_b, k_b, lat);
    check("b_miss_lat", 128'(lat), 128'(20));
    check("b_miss_pt", plaintext_c, pt_b);
    run_op(1'b0, ct_b, k_b, lat);
    check("b_hit_lat", 128'(lat), 128'(10));
    check("b_hit_pt", plaintext_c, pt_b);

    run_op(1'b0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, '0, lat);
    check("zero_lat", 128'(lat), 128'(20));
    check("zero_pt", plaintext_c, '0);
    run_op(1'b0, ct_c1, k_c1, lat);
    check("c1_again_lat", 128'(lat), 128'(20));
    check("c1_again_pt", plaintext_c, pt_c1);

    // start held high and inputs scrambled throughout a run; the B pair is presented
    // while done is high and must be taken as the next operation.
    k_r  = rand128();
    pt_r = rand128();
    ct_r = enc(pt_r, k_r);
    @(negedge clk);
    ciphertext_in = ct_r;
    key_in = k_r;
    start_c = 1'b1;
    @(posedge clk);
    #1;
    ciphertext_in = rand128();
    key_in = rand128();
    ndone = 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done_c === 1'b1) begin
        ndone++;
        lat = k;
      end
      if (k < 20) begin
        ciphertext_in = rand128();
        key_in = rand128();
      end else begin
        ciphertext_in = ct_b;
        key_in = k_b;
      end
    end
    check("spam_ndone", 128'(ndone), 128'(1));
    check("spam_lat", 128'(lat), 128'(20));
    check("spam_pt", plaintext_c, pt_r);
    @(posedge clk);
    wait_done(1'b0, lat);
    check("b2b_lat", 128'(lat), 128'(20));
    check("b2b_pt", plaintext_c, pt_b);

    // Reset five rounds into a cache hit, then the same key must miss.
    @(negedge clk);
    ciphertext_in = ct_b;
    key_in = k_b;
    start_c = 1'b1;
    @(posedge clk);
    #1;
    start_c = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy_c), '0);
    check("mid_rst_done", 128'(done_c), '0);
    check("mid_rst_pt", plaintext_c, '0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b0, ct_b, k_b, lat);
    check("post_rst_lat", 128'(lat), 128'(20));
    check("post_rst_pt", plaintext_c, pt_b);

    // Random loopback; odd iterations reuse the previous key to exercise cache hits.
    k_l = '0;
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) k_l = rand128();
      pt_l = rand128();
      ct_l = enc(pt_l, k_l);
      run_op(1'b0, ct_l, k_l, lat);
      check("lb_pt_cache", plaintext_c, pt_l);
      check("lb_lat_cache", 128'(lat), 128'((i % 2 == 1) ? 10 : 20));
      run_op(1'b1, ct_l, k_l, lat);
      check("lb_pt_nocache", plaintext_n, pt_l);
      check("lb_lat_nocache", 128'(lat), 128'(20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
